// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit saturating direction counters for the IF stage.
// Trained from EX resolution feedback; lookup is combinational from table state.
module btb_predictor #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] pred_npc,
  output logic            pred_taken,
  input  logic            upd_e,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_mispred,
  output logic [31:0]     br_cnt,
  output logic [31:0]     miss_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [DEPTH-1:0]       r_valid;
  logic [DEPTH-1:0][1:0]  r_ctr;
  logic [TAG_W-1:0]       r_tag    [DEPTH];
  logic [XLEN-1:0]        r_target [DEPTH];
  logic [31:0]            r_br_cnt;
  logic [31:0]            r_miss_cnt;

  logic [IDX_W-1:0]       w_rd_idx;
  logic [TAG_W-1:0]       w_rd_tag;
  logic                   w_rd_hit;
  logic [IDX_W-1:0]       w_up_idx;
  logic [TAG_W-1:0]       w_up_tag;
  logic                   w_up_hit;
  logic [3:0]             w_unused_lsb;

  assign w_unused_lsb = {if_pc[1:0], upd_pc[1:0]};

  // Fetch-side lookup; reset forces a fall-through prediction.
  assign w_rd_idx   = if_pc[IDX_W+1:2];
  assign w_rd_tag   = if_pc[XLEN-1:IDX_W+2];
  assign w_rd_hit   = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign pred_taken = !rst && w_rd_hit && r_ctr[w_rd_idx][1];
  assign pred_npc   = pred_taken ? r_target[w_rd_idx] : if_pc + XLEN'(4);

  assign w_up_idx = upd_pc[IDX_W+1:2];
  assign w_up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Valid bits, direction counters and perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_ctr      <= {DEPTH{2'b01}};
      r_br_cnt   <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (upd_e) begin
      r_br_cnt <= r_br_cnt + 32'd1;
      if (upd_mispred) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
      if (w_up_hit) begin
        if (upd_taken) begin
          if (r_ctr[w_up_idx] != 2'b11) begin
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'd1;
          end
        end else if (r_ctr[w_up_idx] != 2'b00) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= 2'b10;
      end
    end
  end

  // Tag/target payload needs no reset; a taken resolution always (re)writes it.
  always_ff @(posedge clk) begin
    if (!rst && upd_e && upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= upd_target;
    end
  end

  assign br_cnt   = r_br_cnt;
  assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: allocation, hysteresis, aliasing,
// same-cycle read/update, wrap-around and reset behaviour.
module tb_btb_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] pred_npc;
  logic        pred_taken;
  logic        upd_e;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  btb_predictor #(.IDX_W(6), .XLEN(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .if_pc      (if_pc),
    .pred_npc   (pred_npc),
    .pred_taken (pred_taken),
    .upd_e      (upd_e),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .upd_mispred(upd_mispred),
    .br_cnt     (br_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One resolution pulse, then let outputs settle.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mis);
    upd_e = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_mispred = mis;
    tick();
    upd_e = 1'b0; upd_mispred = 1'b0;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                      input logic tk);
    if_pc = pc;
    #1;
    chk({tag, "_npc"}, pred_npc, npc);
    chk({tag, "_tk"}, 32'(pred_taken), 32'(tk));
  endtask

  initial begin
    rst = 1'b1; if_pc = 32'h0; upd_e = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_mispred = 1'b0;
    tick();
    rst = 1'b0;
    look("rst_look", 32'h100, 32'h104, 1'b0);
    chk("rst_br", br_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);

    // Same-cycle allocation: old contents seen this cycle, new next cycle
    upd_e = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80; upd_mispred = 1'b1;
    if_pc = 32'h100;
    #1;
    chk("same_cyc_npc", pred_npc, 32'h104);
    tick();
    upd_e = 1'b0; upd_mispred = 1'b0;
    #1;
    look("alloc", 32'h100, 32'h80, 1'b1);
    chk("alloc_br", br_cnt, 32'd1);
    chk("alloc_miss", miss_cnt, 32'd1);

    // Hysteresis: ctr 2 -> 1 -> 2 -> 3 -> 2 -> 1 -> 0 -> 0 -> 1 -> 2
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    look("ctr1", 32'h100, 32'h104, 1'b0);
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    look("ctr3", 32'h100, 32'h80, 1'b1);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("ctr3to2", 32'h100, 32'h80, 1'b1);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    look("ctr0", 32'h100, 32'h104, 1'b0);
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    look("sat0_then1", 32'h100, 32'h104, 1'b0);
    upd(32'h100, 1'b1, 32'h80, 1'b0);
    look("back_to2", 32'h100, 32'h80, 1'b1);
    chk("hyst_br", br_cnt, 32'd10);
    chk("hyst_miss", miss_cnt, 32'd2);

    // Aliasing at index 0: 0x100 vs 0x200
    look("alias_miss", 32'h200, 32'h204, 1'b0);
    upd(32'h200, 1'b0, 32'h40, 1'b0);
    look("alias_nt_keep", 32'h100, 32'h80, 1'b1);
    upd(32'h200, 1'b1, 32'h40, 1'b0);
    look("alias_evicted", 32'h100, 32'h104, 1'b0);
    look("alias_new", 32'h200, 32'h40, 1'b1);

    // Taken hit rewrites target; not-taken hit keeps it
    upd(32'h200, 1'b1, 32'h44, 1'b0);
    look("tgt_update", 32'h200, 32'h44, 1'b1);
    upd(32'h200, 1'b0, 32'h99, 1'b0);
    look("tgt_keep", 32'h200, 32'h44, 1'b1);
    chk("alias_br", br_cnt, 32'd14);

    look("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

    // Reset with a pending update on the same edge
    rst = 1'b1;
    upd_e = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h10; upd_mispred = 1'b1;
    look("in_rst", 32'h200, 32'h204, 1'b0);
    tick();
    rst = 1'b0; upd_e = 1'b0; upd_mispred = 1'b0;
    #1;
    chk("post_rst_br", br_cnt, 32'd0);
    chk("post_rst_miss", miss_cnt, 32'd0);
    look("post_rst_300", 32'h300, 32'h304, 1'b0);
    look("post_rst_200", 32'h200, 32'h204, 1'b0);
    look("post_rst_100", 32'h100, 32'h104, 1'b0);
    look("post_rst_wrap", 32'hFFFF_FFFC, 32'h0000_0000, 1'b0);

    upd(32'h300, 1'b1, 32'h10, 1'b0);
    look("realloc", 32'h300, 32'h10, 1'b1);
    chk("realloc_br", br_cnt, 32'd1);
    chk("realloc_miss", miss_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Branch target buffer and 2-bit direction predictor in the IF stage. Each cycle it looks up the fetch PC and returns the predicted next PC, which fetch uses and carries down the pipe as `pred`. It is the consuming end of the execute stage's resolution interface (`is_jmp`, `btb_change_e`, `jmp_addr_o`, `jmp_e`). It trains its table from that feedback one cycle after a branch or jump resolves.

## Interface
- IDX_W, 6, index width; table holds 2^IDX_W entries, indexed by PC[IDX_W+1:2]
- XLEN, 32, address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_pc  in  XLEN  current fetch PC, word-aligned
- pred_npc  out  XLEN  predicted next PC (combinational)
- pred_taken  out  1  prediction is taken (combinational)
- upd_e  in  1  resolution valid; driven by EX `is_jmp`
- upd_pc  in  XLEN  PC of the resolved branch or jump
- upd_taken  in  1  actual direction; driven by EX `btb_change_e`
- upd_target  in  XLEN  resolved target; driven by EX `jmp_addr_o`
- upd_mispred  in  1  EX `jmp_e`; counted only
- br_cnt  out  32  resolved branch and jump count
- miss_cnt  out  32  mispredict count

## Operation
- Each entry holds: valid (1), tag PC[XLEN-1:IDX_W+2], target (XLEN), ctr (2-bit saturating).
- Lookup:
  - hit = valid[i] && tag[i] == if_pc tag, where i = if_pc[IDX_W+1:2].
  - pred_taken = hit && ctr[i][1].
  - pred_npc = pred_taken ? target[i] : if_pc + 4, mod 2^XLEN.
- Update on a clock edge with upd_e=1 and rst=0; j = upd_pc index.
  - Hit at j, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit at j, not taken: ctr = max(ctr-1, 0); target is unchanged.
  - Miss at j (invalid or tag mismatch), taken: allocate or replace. valid=1, tag from upd_pc, target=upd_target, ctr=2'b10.
  - Miss at j, not taken: no table change.
- JAL and JALR arrive with upd_taken=1, so they train like taken branches.
- Perf counters (wrap mod 2^32):
  - br_cnt increments on each edge with upd_e=1.
  - miss_cnt increments on each edge with upd_e && upd_mispred.
- upd_mispred never alters the table.

## Timing
- Lookup is zero-latency combinational from table state. Table writes take effect at the next rising edge.
- Same-cycle lookup and update on the same index: the lookup returns pre-update contents. There is no write-through bypass.
- One update per cycle. upd_e is a single-cycle pulse per resolved instruction, with no handshake and no backpressure. The block always accepts.
- rst high:
  - At the edge, all valid=0, all ctr=2'b01, br_cnt=0, miss_cnt=0. Tags and targets are don't-care.
  - During the cycle, pred_taken=0 and pred_npc=if_pc+4 regardless of table state.
  - An upd_e sampled with rst high is dropped: no table write, no count.
- Reset asserted mid-training: an update pending on the same edge is lost. The first post-reset lookup of any PC is a miss.
- Reset values: pred_taken=0, pred_npc=if_pc+4, br_cnt=0, miss_cnt=0.
- if_pc=0xFFFFFFFC on a miss gives pred_npc=0x00000000 (wrap-around).
- Aliasing: two PCs with equal index and different tags evict each other only on a taken resolution. A not-taken resolution of the aliasing PC leaves the resident entry intact.

## Test plan
- Reset then lookup: rst 1 cycle, then if_pc=0x100 -> pred_taken=0, pred_npc=0x104, br_cnt=0.
- Allocate and hit: upd_e, upd_pc=0x100, taken, target=0x80, mispred=1. Next cycle if_pc=0x100 -> pred_taken=1, pred_npc=0x80, br_cnt=1, miss_cnt=1.
- Counter hysteresis:
  - After allocation (ctr=2), one not-taken update -> ctr=1, pred_npc=0x104.
  - Two taken updates from ctr=1 -> ctr=3.
  - Then one not-taken -> ctr=2, still predicts 0x80.
  - Three not-taken then a fourth -> ctr saturates at 0.
- Alias/tag check: entry at 0x100 taken; lookup 0x200 (IDX_W=6, same index) -> miss, pred_npc=0x204.
  - Not-taken update at 0x200 -> 0x100 still hits.
  - Taken update at 0x200, target 0x40 -> 0x100 misses, 0x200 predicts 0x40.
- Same-cycle read/update: if_pc=0x100 with upd_e allocating 0x100 in the same cycle -> pred_npc=0x104 that cycle, 0x80 the next.
- Reset mid-stream: upd_e=1 with rst=1 on the same edge -> no allocation, br_cnt=0, all prior entries miss. Also check the 0xFFFFFFFC miss -> pred_npc=0x0.
